// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned A-B, LSB first through one full-subtractor cell, valid/ready in and out.
module serial_subtractor #(
  parameter int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, sd_q, sd_d, diff_q, diff_d;
  logic bi_q, bi_d, borrow_q, borrow_d;
  logic d, bo, last;
  logic [WIDTH-1:0] sd_sh;
  assign d = sa_q[0] ^ sb_q[0] ^ bi_q;
  assign bo = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & bi_q);
  // new bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB
  assign sd_sh = (sd_q >> 1) | (WIDTH'(d) << (WIDTH - 1));
  assign last = cnt_q == CNT_W'(WIDTH - 1);
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign diff = diff_q;
  assign borrow = borrow_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sa_d = sa_q;
    sb_d = sb_q;
    sd_d = sd_q;
    bi_d = bi_q;
    diff_d = diff_q;
    borrow_d = borrow_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        sa_d = a;
        sb_d = b;
        sd_d = '0;
        bi_d = 1'b0;
        cnt_d = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        sa_d = sa_q >> 1;
        sb_d = sb_q >> 1;
        sd_d = sd_sh;
        bi_d = bo;
        cnt_d = cnt_q + CNT_W'(1);
        if (last) begin
          diff_d = sd_sh;
          borrow_d = bo;
          state_d = DONE;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sa_q <= '0;
      sb_q <= '0;
      sd_q <= '0;
      bi_q <= 1'b0;
      diff_q <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
      sd_q <= sd_d;
      bi_q <= bi_d;
      diff_q <= diff_d;
      borrow_q <= borrow_d;
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench; driver pushes arithmetic expectations, monitor pops on output handshakes.
module tb_serial_subtractor;
  localparam int W = 4;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, borrow;
  logic [W-1:0] a = '0, b = '0, diff;
  typedef struct {logic [W-1:0] d; logic bo; int acc;} exp_t;
  exp_t sb[$];
  exp_t e;
  int n_cmp = 0, n_bad = 0, cyc = 0, hs_edge = -1, acc_edge = -1;
  bit rnd_mode = 0, hold_on = 0, prev_v = 0, saw_v;
  logic [W-1:0] hold_d;
  logic hold_b;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow(borrow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // monitor: handshakes are sampled mid-cycle and complete on the following rising edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !prev_v) begin
        if (sb.size() != 0) chk("latency_edge", cyc, sb[0].acc + W);
        else chk("valid_without_pending", sb.size(), 1);
      end
      if (hold_on) begin
        chk("hold_diff", diff, hold_d);
        chk("hold_borrow", borrow, hold_b);
      end
      hold_on = out_valid && !out_ready;
      hold_d = diff;
      hold_b = borrow;
      if (out_valid && out_ready) begin
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("diff", diff, e.d);
          chk("borrow", borrow, e.bo);
        end else chk("result_without_pending", sb.size(), 1);
        hs_edge = cyc + 1;
      end
      prev_v = out_valid;
    end else begin
      prev_v = 0;
      hold_on = 0;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_mode) out_ready = $urandom_range(0, 3) != 0;
  end

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
    bit ok = 0;
    a = x;
    b = y;
    in_valid = 1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      in_valid = 0;
      return;
    end
    acc_edge = cyc + 1;
    sb.push_back('{d: W'((int'(x) - int'(y)) & ((1 << W) - 1)), bo: x < y, acc: acc_edge});
    @(posedge clk);
    #1;
    in_valid = 0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    out_ready = 1;
    send(9, 3);
    drain();
    @(negedge clk);
    chk("idle_after_result", in_ready, 1);
    @(posedge clk);
    #1;
    send(0, 1);
    send(5, 5);
    drain();
    @(posedge clk);
    #1;
    out_ready = 0;
    send(12, 7);
    a = 1;
    b = 1;
    in_valid = 1;
    for (int i = 0; i < W + 5; i++) begin
      @(negedge clk);
      chk("busy_in_ready", in_ready, 0);
    end
    chk("stalled_valid", out_valid, 1);
    @(posedge clk);
    #1;
    out_ready = 1;
    send(1, 1);
    chk("accept_after_one_idle", acc_edge, hs_edge + 1);
    drain();
    send(15, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_diff", diff, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1;
    saw_v = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      saw_v |= out_valid;
    end
    chk("no_valid_after_midrst", saw_v, 0);
    chk("idle_after_midrst", in_ready, 1);
    @(posedge clk);
    #1;
    rnd_mode = 1;
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        send(W'(ia), W'(ib));
      end
    rnd_mode = 0;
    @(posedge clk);
    #1;
    out_ready = 1;
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
